// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the tile configuration frame loader:
// loader state encoding, CRC-8 constants and the per-word CRC update.
package kfpga_config_pkg;

    // Loader state encoding; CHECK is only reachable with CONFIG_FRAME_LOADER_CRC_EN.
    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_LOAD   = 2'd1,
        LD_CHECK  = 2'd2,
        LD_COMMIT = 2'd3
    } loader_state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // CRC-8 (poly 0x07) over one byte, MSB first.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] word);
        logic [7:0] c;
        c = crc ^ word;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/config_crc8.sv
// Registered CRC-8 accumulator. clear restarts from CRC8_INIT, enable folds
// one data byte in. clear has priority over enable.
module config_crc8
    import kfpga_config_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_q;

    // Accumulate one byte per enabled cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            crc_q <= CRC8_INIT;
        end else if (clear) begin
            crc_q <= CRC8_INIT;
        end else if (enable) begin
            crc_q <= crc8_update(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/config_frame_loader.sv
// Tile configuration frame loader. Words from the configuration bus are
// assembled in a shadow register; the complete frame is copied to config_out
// in a single edge (COMMIT), so the switch box never sees a partial frame.
// Optional macro CONFIG_FRAME_LOADER_CRC_EN adds a trailing CRC-8 word that
// must match before the commit; mismatch pulses error instead of done.
//
// Handshake: a word is transferred on a rising edge where word_valid and
// word_ready are both high. word_ready depends on state only (high in LOAD
// and CHECK), never on word_valid. abort in LOAD/CHECK beats a coincident
// transfer: that word is dropped.
module config_frame_loader
    import kfpga_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = 160,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    load_start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic [1:0]              state_dbg
);

    localparam int NUM_WORDS = CONFIG_WIDTH / WORD_WIDTH;
    localparam int CNT_W     = $clog2(NUM_WORDS);

    localparam logic [1:0] ST_IDLE   = LD_IDLE;
    localparam logic [1:0] ST_LOAD   = LD_LOAD;
    localparam logic [1:0] ST_CHECK  = LD_CHECK;
    localparam logic [1:0] ST_COMMIT = LD_COMMIT;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [CONFIG_WIDTH-1:0] shadow;
    logic                    hs;

    assign word_ready = (state == ST_LOAD) || (state == ST_CHECK);
    assign busy       = (state != ST_IDLE);
    assign hs         = word_valid && word_ready;
    assign state_dbg  = state;

`ifdef CONFIG_FRAME_LOADER_CRC_EN
    logic [7:0] crc_value;
    logic       crc_match;
    logic       err_q;

    if (WORD_WIDTH != 8) begin : g_width_check
        $error("config_frame_loader: CRC option needs WORD_WIDTH == 8");
    end

    config_crc8 u_crc (
        .clock  (clock),
        .nreset (nreset),
        .clear  ((state == ST_IDLE) && load_start),
        .enable ((state == ST_LOAD) && hs && !abort),
        .data   (word_in[7:0]),
        .crc    (crc_value)
    );

    assign crc_match = (word_in[7:0] == crc_value);

    // One-cycle error pulse after a mismatching CRC word (abort suppresses it).
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ST_CHECK) && hs && !abort && !crc_match;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    // Frame FSM, word counter, shadow assembly and atomic commit.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shadow     <= '0;
            config_out <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (hs) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            if (cnt == CNT_W'(i)) begin
                                shadow[i*WORD_WIDTH +: WORD_WIDTH] <= word_in;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
`ifdef CONFIG_FRAME_LOADER_CRC_EN
                            state <= ST_CHECK;
`else
                            state <= ST_COMMIT;
`endif
                        end
                    end
                end
`ifdef CONFIG_FRAME_LOADER_CRC_EN
                ST_CHECK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (hs) begin
                        state <= crc_match ? ST_COMMIT : ST_IDLE;
                    end
                end
`endif
                ST_COMMIT: begin
                    config_out <= shadow;
                    done       <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: normal load, stalls, abort,
// reset mid-frame, back-to-back frames and (with CONFIG_FRAME_LOADER_CRC_EN)
// CRC match/mismatch.
module tb_config_frame_loader;

  localparam int CW = 160;
  localparam int WW = 8;
  localparam int NW = 20;

  logic          clock;
  logic          nreset;
  logic          load_start;
  logic          abort;
  logic [WW-1:0] word_in;
  logic          word_valid;
  logic          word_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] config_out;
  logic [1:0]    state_dbg;

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] last_cfg;

  config_frame_loader #(.CONFIG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .load_start (load_start),
    .abort      (abort),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .config_out (config_out),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // helpers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] make_frame(input logic [7:0] base, input logic [7:0] step);
    logic [CW-1:0] d;
    logic [7:0] v;
    d = '0;
    v = base;
    for (int i = 0; i < NW; i++) begin
      d[i*8 +: 8] = v;
      v = v + step;
    end
    return d;
  endfunction

  // bit-serial CRC-8 reference, poly 0x07, init 0, MSB first
  function automatic logic [7:0] ref_crc(input logic [CW-1:0] d);
    logic [7:0] c;
    logic [7:0] w;
    logic fb;
    c = 8'h00;
    for (int i = 0; i < NW; i++) begin
      w = d[i*8 +: 8];
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ w[b];
        c = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  // driver tasks
  task automatic start_frame(input string tag);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic send_word(input logic [7:0] w, input string tag);
    word_valid = 1'b1;
    word_in    = w;
    chk({tag, "_ready"}, word_ready, 1);
    tick();
    word_valid = 1'b0;
    word_in    = 8'h00;
  endtask

  task automatic send_data(input logic [CW-1:0] d, input int first, input int last,
                           input bit stall, input string tag);
    for (int i = first; i <= last; i++) begin
      if (stall) begin
        tick();
        chk({tag, "_stall_no_done"}, done, 0);
      end
      send_word(d[i*8 +: 8], tag);
    end
  endtask

  task automatic finish_frame(input logic [CW-1:0] d, input string tag);
    int n;
    logic [CW-1:0] e;
`ifdef CONFIG_FRAME_LOADER_CRC_EN
    send_word(ref_crc(d), {tag, "_crc"});
`endif
    n = 1;
    while (done !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_done_latency"}, CW'(n), CW'(2));
    chk({tag, "_error_low"}, error, 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_config"}, config_out, e);
      last_cfg = e;
    end
    chk({tag, "_busy_low_at_done"}, busy, 0);
  endtask

  task automatic run_frame(input logic [CW-1:0] d, input bit stall, input string tag);
    exp_q.push_back(d);
    start_frame(tag);
    send_data(d, 0, NW - 1, stall, tag);
    finish_frame(d, tag);
  endtask

  // directed sequence
  logic [CW-1:0] ramp;
  logic [CW-1:0] fa;
  logic [CW-1:0] fb;
  logic [CW-1:0] fc;
  logic [CW-1:0] ones;

  initial begin
    nreset     = 1'b0;
    load_start = 1'b0;
    abort      = 1'b0;
    word_in    = 8'h00;
    word_valid = 1'b0;
    last_cfg   = '0;
    ramp = make_frame(8'h00, 8'h01);
    fa   = make_frame(8'h11, 8'h07);
    fb   = ~fa;
    fc   = make_frame(8'h5A, 8'h03);
    ones = make_frame(8'hFF, 8'h00);

    // reset state
    tick();
    tick();
    chk("rst_config", config_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_state", state_dbg, 0);
    nreset = 1'b1;
    tick();
    chk("idle_ready", word_ready, 0);

    // normal load
    run_frame(ramp, 1'b0, "ramp");
    chk("ramp_low_byte", config_out[7:0], 8'h00);
    chk("ramp_high_byte", config_out[159:152], 8'h13);
    tick();
    chk("ramp_done_drop", done, 0);
    chk("ramp_config_hold", config_out, ramp);

    // stalls every other cycle
    run_frame(ramp, 1'b1, "stall");
    tick();

    // abort mid-frame with a coincident valid word
    run_frame(fa, 1'b0, "cfg_a");
    tick();
    start_frame("abort");
    send_data(fb, 0, 9, 1'b0, "abort");
    word_valid = 1'b1;
    word_in    = fb[10*8 +: 8];
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    word_valid = 1'b0;
    chk("abort_ready", word_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", state_dbg, 0);
    chk("abort_done", done, 0);
    chk("abort_config", config_out, fa);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", done, 0);
      chk("abort_config_hold", config_out, fa);
    end
    chk("abort_error", error, 0);

    // reset in the middle of a frame
    start_frame("midrst");
    send_data(fc, 0, 5, 1'b0, "midrst");
    #1;
    nreset = 1'b0;
    #1;
    chk("midrst_config", config_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", word_ready, 0);
    chk("midrst_state", state_dbg, 0);
    tick();
    nreset = 1'b1;
    tick();
    run_frame(fc, 1'b0, "after_rst");

    // back-to-back: second load_start in the done cycle
    run_frame(ramp, 1'b0, "b2b_first");
    run_frame(ones, 1'b0, "b2b_ones");
    chk("b2b_all_ones", config_out, {CW{1'b1}});
    tick();

`ifdef CONFIG_FRAME_LOADER_CRC_EN
    // CRC mismatch: error pulse, no commit
    start_frame("badcrc");
    send_data(fc, 0, NW - 1, 1'b0, "badcrc");
    send_word(ref_crc(fc) ^ 8'h01, "badcrc_crc");
    chk("badcrc_error", error, 1);
    chk("badcrc_done", done, 0);
    chk("badcrc_config", config_out, last_cfg);
    chk("badcrc_busy", busy, 0);
    tick();
    chk("badcrc_error_pulse", error, 0);
    chk("badcrc_no_done", done, 0);
    chk("badcrc_config_hold", config_out, last_cfg);
    run_frame(fa, 1'b0, "crc_good");
`endif

    chk("final_error_low", error, 0);
    chk("queue_drained", CW'(exp_q.size()), CW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
